// File: rtl/openhmc_rf_master.sv
// openhmc_rf_master: serialises host RF commands into single-cycle RF enable pulses and returns data/status.
// Latency: accept at T, enable pulse at T+1, response the cycle after RF completion (>= T+3).
// Backpressure: cmd_ready low while an access is in flight; rsp_* held stable until rsp_ready.
// Build option: define OPENHMC_RF_MASTER_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module openhmc_rf_master #(
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_hmc,
  input  logic                     res_hmc,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [HMC_RF_AWIDTH-1:0] cmd_addr,
  input  logic [HMC_RF_WWIDTH-1:0] cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [HMC_RF_RWIDTH-1:0] rsp_rdata,
  output logic                     rsp_invalid,
  output logic                     rsp_timeout,
  output logic [HMC_RF_AWIDTH-1:0] rf_address,
  output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
  output logic                     rf_read_en,
  output logic                     rf_write_en,
  input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
  input  logic                     rf_access_complete,
  input  logic                     rf_invalid_address
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic                     r_cmd_ready;
  logic                     r_write;
  logic                     r_inv;
  logic [HMC_RF_AWIDTH-1:0] r_rf_address;
  logic [HMC_RF_WWIDTH-1:0] r_rf_write_data;
  logic                     r_rf_read_en;
  logic                     r_rf_write_en;
  logic                     r_rsp_write;
  logic [HMC_RF_RWIDTH-1:0] r_rsp_rdata;
  logic                     r_rsp_invalid;

  logic w_cmd_acc;
  logic w_rsp_hs;
  logic w_done;
  logic w_tmo;
  logic w_inv_now;

  // Completion and invalid-address are only honoured while in WAIT
  assign w_cmd_acc = cmd_valid & r_cmd_ready;
  assign w_rsp_hs  = (r_state == ST_RESP) & rsp_ready;
  assign w_done    = (r_state == ST_WAIT) & rf_access_complete;
  assign w_inv_now = r_inv | rf_invalid_address;

`ifdef OPENHMC_RF_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_timeout;

  // A completion in the cycle the count reaches the limit still wins
  assign w_tmo = (r_state == ST_WAIT) & ~rf_access_complete & (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // WAIT-cycle counter: reads 1 in the first WAIT cycle
  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      r_cnt <= '0;
    end else if (w_cmd_acc) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= CNT_W'(1);
    end else if ((r_state == ST_WAIT) & ~w_done & ~w_tmo) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Timeout status is captured alongside the other response fields
  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_done) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo        = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  // Next-state selection for the IDLE -> ISSUE -> WAIT -> RESP loop
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_acc) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  if (w_done | w_tmo) w_next_state = ST_RESP;
      ST_RESP:  if (w_rsp_hs) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register; cmd_ready is registered so it rises one edge after reset release
  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == ST_IDLE);
    end
  end

  // Capture the command on accept and fire exactly one enable pulse in the following cycle
  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      r_rf_address    <= '0;
      r_rf_write_data <= '0;
      r_write         <= 1'b0;
      r_rf_read_en    <= 1'b0;
      r_rf_write_en   <= 1'b0;
    end else begin
      r_rf_read_en  <= w_cmd_acc & ~cmd_write;
      r_rf_write_en <= w_cmd_acc & cmd_write;
      if (w_cmd_acc) begin
        r_rf_address    <= cmd_addr;
        r_rf_write_data <= cmd_wdata;
        r_write         <= cmd_write;
      end
    end
  end

  // Sticky invalid-address flag over the WAIT window
  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      r_inv <= 1'b0;
    end else if (w_cmd_acc) begin
      r_inv <= 1'b0;
    end else if ((r_state == ST_WAIT) & rf_invalid_address) begin
      r_inv <= 1'b1;
    end
  end

  // Response fields; read data only passes for a valid read, and a timeout never reports invalid
  always_ff @(posedge clk_hmc or posedge res_hmc) begin
    if (res_hmc) begin
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_invalid <= 1'b0;
    end else if (w_done) begin
      r_rsp_write   <= r_write;
      r_rsp_invalid <= w_inv_now;
      r_rsp_rdata   <= (~r_write & ~w_inv_now) ? rf_read_data : '0;
    end else if (w_tmo) begin
      r_rsp_write   <= r_write;
      r_rsp_invalid <= 1'b0;
      r_rsp_rdata   <= '0;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_invalid   = r_rsp_invalid;
  assign rf_address    = r_rf_address;
  assign rf_write_data = r_rf_write_data;
  assign rf_read_en    = r_rf_read_en;
  assign rf_write_en   = r_rf_write_en;

endmodule

// File: tb/tb_openhmc_rf_master.sv
// tb_openhmc_rf_master: randomized command/RF-response stimulus with a queue-based scoreboard.
// The driver plans each RF reply (delay, invalid pulses, data) and pushes the expected response;
// a separate monitor pops and compares whenever rsp_valid is seen, and randomly backpressures.
module tb_openhmc_rf_master;

  localparam int AW  = 4;
  localparam int WW  = 64;
  localparam int RW  = 64;
  localparam int TMO = 4;
`ifdef OPENHMC_RF_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk_hmc = 1'b0;
  logic          res_hmc;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [WW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_invalid, rsp_timeout;
  logic [RW-1:0] rsp_rdata;
  logic [AW-1:0] rf_address;
  logic [WW-1:0] rf_write_data;
  logic          rf_read_en, rf_write_en;
  logic [RW-1:0] rf_read_data;
  logic          rf_access_complete, rf_invalid_address;

  openhmc_rf_master #(
    .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_hmc(clk_hmc), .res_hmc(res_hmc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
    .rf_address(rf_address), .rf_write_data(rf_write_data),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
    .rf_read_data(rf_read_data), .rf_access_complete(rf_access_complete),
    .rf_invalid_address(rf_invalid_address)
  );

  always #5 clk_hmc = ~clk_hmc;

  int cyc = 0;
  always @(posedge clk_hmc) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [63:0] rdata;
    logic        inv;
    logic        tmo;
    int          cyc;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cyc = -100;
  int   exp_issue_cyc = -1;
  logic exp_issue_w = 1'b0;
  int   stall_tok = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: the response a command should produce given the planned RF behaviour
  function automatic rsp_t model(input logic wr, input logic [63:0] data, input int d,
                                 input logic [7:0] inv, input int t);
    rsp_t r;
    logic any_inv;
    r.wr = wr;
    if (TMO_EN && d > TMO) begin
      r.tmo = 1'b1; r.inv = 1'b0; r.rdata = 64'd0; r.cyc = t + 2 + TMO;
    end else begin
      any_inv = 1'b0;
      for (int k = 1; k <= d; k++) any_inv = any_inv | inv[k];
      r.tmo = 1'b0; r.inv = any_inv;
      r.rdata = (!wr && !any_inv) ? data : 64'd0;
      r.cyc = t + 2 + d;
    end
    return r;
  endfunction

  // Enable pulses: exactly the planned one in the cycle after accept, never both
  always @(negedge clk_hmc) begin : en_chk
    logic [1:0] e;
    if (!res_hmc) begin
      e = (cyc == exp_issue_cyc) ? (exp_issue_w ? 2'b01 : 2'b10) : 2'b00;
      chk("enable_pulse", 64'({rf_read_en, rf_write_en}), 64'(e));
    end
  end

  // Monitor: compares every cycle the response is presented, so stalls also check stability
  initial begin : mon
    int   stall_left = 0;
    int   stall_seen = 0;
    bit   in_rsp = 1'b0;
    rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk_hmc);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          rsp_ready = 1'b1;
        end else begin
          e = exp_q[0];
          if (!in_rsp) begin
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            in_rsp = 1'b1;
            if (stall_tok != stall_seen) begin
              stall_left = 10;
              stall_seen = stall_tok;
            end
          end
          chk("rsp_write",   64'(rsp_write),   64'(e.wr));
          chk("rsp_rdata",   rsp_rdata,        e.rdata);
          chk("rsp_invalid", 64'(rsp_invalid), 64'(e.inv));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
          chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'd0);
          if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
          end else begin
            rsp_ready = 1'($urandom_range(0, 1));
          end
          if (rsp_ready) begin
            hs_cyc = cyc;
            void'(exp_q.pop_front());
            in_rsp = 1'b0;
          end
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    repeat (40000) @(posedge clk_hmc);
    $display("FAIL watchdog cycle budget exhausted actual=%0d expected<40000", cyc);
    $fatal(1, "watchdog");
  end

  // Offer a command, then play the RF side: noise in ISSUE, completion d cycles after ISSUE
  task automatic run_cmd(input logic wr, input logic [3:0] addr, input logic [63:0] wd,
                         input logic [63:0] rd, input int d, input logic [7:0] inv,
                         input logic nz_c, input logic nz_i);
    int offer, t, n, exp_acc;
    offer = cyc;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk_hmc);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait actual=no_accept expected=accept within 300 cycles");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "accept wait expired");
    end
    t = cyc;
    exp_acc = (offer > hs_cyc + 1) ? offer : hs_cyc + 1;
    chk("accept_cycle", 64'(t), 64'(exp_acc));
    exp_issue_cyc = t + 1;
    exp_issue_w   = wr;
    exp_q.push_back(model(wr, rd, d, inv, t));
    @(negedge clk_hmc);
    cmd_valid = 1'b0;
    cmd_addr  = 4'($urandom);
    cmd_wdata = {$urandom, $urandom};
    cmd_write = 1'($urandom);
    chk("rf_address", 64'(rf_address), 64'(addr));
    chk("rf_write_data", rf_write_data, wd);
    chk("cmd_ready_issue", 64'(cmd_ready), 64'd0);
    rf_access_complete = nz_c;
    rf_invalid_address = nz_i;
    rf_read_data = {$urandom, $urandom};
    for (int k = 1; k <= d; k++) begin
      @(negedge clk_hmc);
      chk("addr_hold", 64'(rf_address), 64'(addr));
      rf_access_complete = (k == d);
      rf_invalid_address = inv[k];
      rf_read_data = (k == d) ? rd : {$urandom, $urandom};
    end
    @(negedge clk_hmc);
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_hmc);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk_hmc);
  endtask

  initial begin : main
    logic [7:0] inv;
    res_hmc = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rf_read_data = '0; rf_access_complete = 1'b0; rf_invalid_address = 1'b0;
    repeat (3) @(negedge clk_hmc);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_enables", 64'({rf_read_en, rf_write_en}), 64'd0);
    chk("rst_rf_address", 64'(rf_address), 64'd0);
    chk("rst_rf_wdata", rf_write_data, 64'd0);
    chk("rst_rsp_fields", 64'({rsp_write, rsp_invalid, rsp_timeout}), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    res_hmc = 1'b0;
    #1 chk("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
    @(negedge clk_hmc);
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // Directed cases
    run_cmd(1'b0, 4'h2, 64'h1111, 64'hDEAD_BEEF_0123_4567, 2, 8'h00, 1'b0, 1'b0);
    run_cmd(1'b1, 4'h2, 64'h55, 64'hFFFF_0000_FFFF_0000, 1, 8'h00, 1'b0, 1'b0);
    run_cmd(1'b1, 4'h0, 64'h77, 64'h1234, 2, 8'h02, 1'b0, 1'b0);
    run_cmd(1'b0, 4'h8, 64'h0, 64'hCAFE, 2, 8'h02, 1'b0, 1'b0);
    run_cmd(1'b0, 4'h3, 64'h0, 64'hA5A5_5A5A, 3, 8'h00, 1'b1, 1'b1);
    run_cmd(1'b0, 4'h9, 64'h0, 64'hBEEF, 4, 8'h00, 1'b0, 1'b0);
    drain();
    stall_tok++;
    run_cmd(1'b0, 4'h5, 64'h0, 64'h0BAD_F00D, 1, 8'h00, 1'b0, 1'b0);
    run_cmd(1'b1, 4'h6, 64'h66, 64'h0, 1, 8'h00, 1'b0, 1'b0);
    // Never completes in time with the counter enabled; late completion at T+8
    run_cmd(1'b0, 4'h4, 64'h0, 64'hFEED, 7, 8'h00, 1'b0, 1'b0);
    run_cmd(1'b0, 4'h4, 64'h0, 64'h600D, 1, 8'h00, 1'b0, 1'b0);
    drain();

    // Reset during WAIT
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 64'hABCD;
    while (cmd_ready !== 1'b1) @(negedge clk_hmc);
    exp_issue_cyc = cyc + 1;
    exp_issue_w   = 1'b1;
    @(negedge clk_hmc);
    cmd_valid = 1'b0;
    @(negedge clk_hmc);
    res_hmc = 1'b1;
    exp_issue_cyc = -1;
    #1;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_enables", 64'({rf_read_en, rf_write_en}), 64'd0);
    chk("mid_rst_rf_address", 64'(rf_address), 64'd0);
    chk("mid_rst_rf_wdata", rf_write_data, 64'd0);
    chk("mid_rst_rsp_fields", 64'({rsp_write, rsp_invalid, rsp_timeout}), 64'd0);
    rf_access_complete = 1'b1;
    repeat (2) @(negedge clk_hmc);
    rf_access_complete = 1'b0;
    res_hmc = 1'b0;
    #1 chk("mid_rst_release_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk_hmc);
    chk("mid_rst_ready_after", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk_hmc);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      inv = 8'h00;
      for (int k = 1; k < 8; k++) inv[k] = ($urandom_range(0, 5) == 0);
      run_cmd(1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(1, 7)), inv, 1'($urandom), 1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
